realtank_soc_bus_in_stage: RTL

REALTANK_SOC_BUS_IN_STAGE -- requirements
Module: realtank_soc_bus_in_stage

---
 rtl/realtank_soc_bus_in_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/realtank_soc_bus_in_stage.sv
// AHB bus-matrix input stage: holds a master address phase that the
// decoder cannot accept yet and replays it once the target is ready.
module realtank_soc_bus_in_stage (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HREADYS,
    output logic        sel_dec,
    output logic [21:0] decode_addr_dec,
    output logic [31:0] addr_out,
    output logic [1:0]  trans_dec,
    output logic        write_out,
    output logic [2:0]  size_out,
    output logic [2:0]  burst_out,
    output logic [3:0]  prot_out,
    output logic        held_tran,
    input  logic        active_dec,
    input  logic        readyout_dec,
    input  logic [1:0]  resp_dec,
    output logic        HREADYOUTS,
    output logic [1:0]  HRESPS
);

    logic        w_tv;
    logic        w_load;
    logic        w_live_launch;
    logic        w_held_launch;
    logic        w_launch;

    logic        r_pend;
    logic        r_dphase;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_write;
    logic [2:0]  r_size;
    logic [2:0]  r_burst;
    logic [3:0]  r_prot;

    assign w_tv          = HSELS & HTRANSS[1] & HREADYS;
    assign w_load        = w_tv & ~active_dec & ~r_pend;
    assign w_live_launch = w_tv & active_dec & ~r_pend;
    assign w_held_launch = r_pend & active_dec & readyout_dec;
    assign w_launch      = w_live_launch | w_held_launch;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_trans <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
        end else if (w_load) begin
            r_addr  <= HADDRS;
            r_trans <= HTRANSS;
            r_write <= HWRITES;
            r_size  <= HSIZES;
            r_burst <= HBURSTS;
            r_prot  <= HPROTS;
        end
    end

    // An ERROR completion does not touch r_pend: the held transfer survives.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend <= 1'b0;
        end else if (w_load) begin
            r_pend <= 1'b1;
        end else if (w_held_launch) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dphase <= 1'b0;
        end else if (w_launch) begin
            r_dphase <= 1'b1;
        end else if (readyout_dec) begin
            r_dphase <= 1'b0;
        end
    end

    always_comb begin
        sel_dec   = HSELS;
        addr_out  = HADDRS;
        trans_dec = HTRANSS;
        write_out = HWRITES;
        size_out  = HSIZES;
        burst_out = HBURSTS;
        prot_out  = HPROTS;
        if (r_pend) begin
            sel_dec   = 1'b1;
            addr_out  = r_addr;
            // A replayed SEQ starts a fresh access at the target.
            trans_dec = (r_trans == 2'b11) ? 2'b10 : r_trans;
            write_out = r_write;
            size_out  = r_size;
            burst_out = r_burst;
            prot_out  = r_prot;
        end
    end

    assign decode_addr_dec = addr_out[31:10];
    assign held_tran       = r_pend;

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 2'b00;
        if (r_dphase) begin
            HREADYOUTS = readyout_dec;
            HRESPS     = resp_dec;
        end else if (r_pend) begin
            HREADYOUTS = 1'b0;
        end
    end

endmodule
